// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single memory data port.
// Optional lock lets the current owner keep the port for a bounded burst of accesses.
module mem_port_arbiter #(
    parameter int unsigned n        = 8,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         we0,
    input  logic [n-1:0] addr0,
    input  logic [n-1:0] wdata0,
    input  logic         lock0,
    output logic         gnt0,
    output logic         done0,
    input  logic         req1,
    input  logic         we1,
    input  logic [n-1:0] addr1,
    input  logic [n-1:0] wdata1,
    input  logic         lock1,
    output logic         gnt1,
    output logic         done1,
    output logic [n-1:0] rdata,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wr_data,
    output logic         mem_wr_en,
    input  logic [n-1:0] mem_rd_data,
    output logic         owner,
    output logic         busy
);

    localparam int unsigned CntW = $clog2(MAX_LOCK + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_LOCK);

    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StAcc  = 2'b01;
    localparam logic [1:0] StDone = 2'b10;

    logic [1:0]      state_q, state_d;
    logic            gnt0_q, gnt0_d;
    logic            gnt1_q, gnt1_d;
    logic            done0_q, done0_d;
    logic            done1_q, done1_d;
    logic            mem_wr_en_q, mem_wr_en_d;
    logic            busy_q, busy_d;
    logic [n-1:0]    mem_addr_q, mem_addr_d;
    logic [n-1:0]    mem_wr_data_q, mem_wr_data_d;
    logic [n-1:0]    rdata_q, rdata_d;
    logic            owner_q, owner_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic            lock_held_q, lock_held_d;
    logic            winner;

    // The owner keeps the port on a tie only while its lock burst has budget left.
    always_comb begin
        winner = ~owner_q;
        if (req0 && !req1) begin
            winner = 1'b0;
        end else if (req1 && !req0) begin
            winner = 1'b1;
        end else if (lock_held_q && (lock_cnt_q < CntMax)) begin
            winner = owner_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt0_d        = gnt0_q;
        gnt1_d        = gnt1_q;
        done0_d       = done0_q;
        done1_d       = done1_q;
        mem_wr_en_d   = mem_wr_en_q;
        busy_d        = busy_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        rdata_d       = rdata_q;
        owner_d       = owner_q;
        lock_cnt_d    = lock_cnt_q;
        lock_held_d   = lock_held_q;

        case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    gnt0_d        = ~winner;
                    gnt1_d        = winner;
                    busy_d        = 1'b1;
                    owner_d       = winner;
                    mem_addr_d    = winner ? addr1 : addr0;
                    mem_wr_data_d = winner ? wdata1 : wdata0;
                    mem_wr_en_d   = winner ? we1 : we0;
                    if (winner == owner_q) begin
                        if (lock_held_q && (lock_cnt_q < CntMax)) begin
                            lock_cnt_d = lock_cnt_q + CntW'(1);
                        end
                    end else begin
                        lock_cnt_d = '0;
                    end
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (!mem_wr_en_q) begin
                    rdata_d = mem_rd_data;
                end
                mem_wr_en_d = 1'b0;
                gnt0_d      = 1'b0;
                gnt1_d      = 1'b0;
                done0_d     = ~owner_q;
                done1_d     = owner_q;
                state_d     = StDone;
            end
            StDone: begin
                if (owner_q ? lock1 : lock0) begin
                    lock_held_d = 1'b1;
                end else begin
                    lock_held_d = 1'b0;
                    lock_cnt_d  = '0;
                end
                done0_d = 1'b0;
                done1_d = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                gnt0_d      = 1'b0;
                gnt1_d      = 1'b0;
                done0_d     = 1'b0;
                done1_d     = 1'b0;
                mem_wr_en_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            busy_q        <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            rdata_q       <= '0;
            owner_q       <= 1'b1;
            lock_cnt_q    <= '0;
            lock_held_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            mem_wr_en_q   <= mem_wr_en_d;
            busy_q        <= busy_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            rdata_q       <= rdata_d;
            owner_q       <= owner_d;
            lock_cnt_q    <= lock_cnt_d;
            lock_held_q   <= lock_held_d;
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign busy        = busy_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign rdata       = rdata_q;
    assign owner       = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed arbitration/lock/reset scenarios plus a random
// phase, all checked against a transaction-level model of the arbitration rules and memory.
module tb_mem_port_arbiter;

    localparam int MaxLock = 4;

    logic       clk;
    logic       reset;
    logic       req0, we0, lock0, req1, we1, lock1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, done0, gnt1, done1, mem_wr_en, owner, busy;
    logic [7:0] rdata, mem_addr, mem_wr_data, mem_rd_data;

    logic [7:0] mem [256] = '{default: 8'h00};
    logic       ld_en;
    logic [7:0] ld_addr, ld_data;

    // Reference model state
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    bit         m_owner;
    bit         m_locked;
    int         m_streak;
    logic [7:0] m_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.n(8), .MAX_LOCK(MaxLock)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .we0        (we0),
        .addr0      (addr0),
        .wdata0     (wdata0),
        .lock0      (lock0),
        .gnt0       (gnt0),
        .done0      (done0),
        .req1       (req1),
        .we1        (we1),
        .addr1      (addr1),
        .wdata1     (wdata1),
        .lock1      (lock1),
        .gnt1       (gnt1),
        .done1      (done1),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_data(mem_rd_data),
        .owner      (owner),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end
    assign mem_rd_data = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (failure #%0d)", tag, obs, exp, n_fail);
        end
    endtask

    // One arbitration round from an IDLE cycle: predict the winner, check ACC and DONE,
    // then release the winner's request unless it immediately reissues.
    task automatic round(input bit keep0, input bit keep1, output bit w);
        bit         we, lk;
        logic [7:0] a, d;
        if (req0 && !req1) w = 1'b0;
        else if (req1 && !req0) w = 1'b1;
        else if (m_locked && m_streak < MaxLock) w = m_owner;
        else w = !m_owner;
        if (w != m_owner) m_streak = 0;
        else if (m_locked && m_streak < MaxLock) m_streak = m_streak + 1;
        m_owner = w;
        we = w ? we1 : we0;
        a  = w ? addr1 : addr0;
        d  = w ? wdata1 : wdata0;
        lk = w ? lock1 : lock0;

        @(posedge clk); @(negedge clk);
        chk("acc_gnt0", gnt0, !w);
        chk("acc_gnt1", gnt1, w);
        chk("acc_done", {done0, done1}, 2'b00);
        chk("acc_addr", mem_addr, a);
        chk("acc_wr_en", mem_wr_en, we);
        if (we) chk("acc_wdata", mem_wr_data, d);
        chk("acc_owner", owner, w);
        chk("acc_busy", busy, 1'b1);
        if (we) ref_mem[a] = d;
        else m_rdata = ref_mem[a];

        @(posedge clk); @(negedge clk);
        chk("done_done0", done0, !w);
        chk("done_done1", done1, w);
        chk("done_gnt", {gnt0, gnt1}, 2'b00);
        chk("done_wr_en", mem_wr_en, 1'b0);
        chk("done_rdata", rdata, m_rdata);
        chk("done_busy", busy, 1'b1);
        if (w) req1 = keep1;
        else req0 = keep0;
        m_locked = lk;
        if (!lk) m_streak = 0;

        @(posedge clk); @(negedge clk);
        chk("idle_done", {done0, done1}, 2'b00);
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        bit w;
        reset = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00; lock0 = 1'b0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00; lock1 = 1'b0;
        ld_en = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
        m_owner = 1'b1; m_locked = 1'b0; m_streak = 0; m_rdata = 8'h00;

        // Preload memory while in reset
        ld_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            ld_addr = (i == 16) ? 8'h10 : 8'h40 + 8'(i);
            ld_data = (i == 16) ? 8'h5A : 8'($urandom);
            ref_mem[ld_addr] = ld_data;
            @(posedge clk); @(negedge clk);
        end
        ld_en = 1'b0;

        // Reset held with req0 asserted
        req0 = 1'b1; addr0 = 8'h10;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("rst_gnt", {gnt0, gnt1}, 2'b00);
        chk("rst_done", {done0, done1}, 2'b00);
        chk("rst_busy_we", {busy, mem_wr_en}, 2'b00);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_wdata", mem_wr_data, 8'h00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_owner", owner, 1'b1);

        // Read of 0x10 right after reset release
        reset = 1'b1;
        round(1'b0, 1'b0, w);
        chk("rd_winner", w, 1'b0);
        chk("rd_rdata", rdata, 8'h5A);

        // Write leaves rdata alone
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'hC3;
        round(1'b0, 1'b0, w);
        chk("wr_rdata_kept", rdata, 8'h5A);
        chk("wr_mem20", mem[8'h20], 8'hC3);

        // Round-robin with both requesting, no lock
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
        for (int k = 0; k < 4; k++) begin
            round(1'b1, 1'b1, w);
            chk("alt_winner", w, (k % 2 == 0));
        end

        // Requester 1 locks: 5 grants in a row, then requester 0
        lock1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            round(1'b1, 1'b1, w);
            chk("lock1_winner", w, (k < 5));
        end
        lock1 = 1'b0;
        round(1'b1, 1'b0, w);
        chk("lock1_drain1", w, 1'b1);
        round(1'b0, 1'b0, w);
        chk("lock1_drain0", w, 1'b0);

        // Requester 0 locks alone for 8 accesses, then requester 1 arrives
        req0 = 1'b1; lock0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            round(1'b1, 1'b0, w);
            chk("lock0_winner", w, 1'b0);
        end
        req1 = 1'b1;
        round(1'b1, 1'b0, w);
        chk("lock0_preempt", w, 1'b1);
        lock0 = 1'b0;
        round(1'b0, 1'b0, w);
        chk("lock0_final", w, 1'b0);

        // Random traffic in 0x40..0x4F
        for (int k = 0; k < 80; k++) begin
            if (!req0 && $urandom_range(0, 1) == 1) begin
                req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
                addr0 = 8'h40 + 8'($urandom_range(0, 15)); wdata0 = 8'($urandom);
                lock0 = 1'($urandom_range(0, 1));
            end
            if (!req1 && $urandom_range(0, 1) == 1) begin
                req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
                addr1 = 8'h40 + 8'($urandom_range(0, 15)); wdata1 = 8'($urandom);
                lock1 = 1'($urandom_range(0, 1));
            end
            if (req0 || req1) begin
                round(1'b0, 1'b0, w);
            end else begin
                @(posedge clk); @(negedge clk);
                chk("rnd_idle_gnt", {gnt0, gnt1}, 2'b00);
                chk("rnd_idle_busy", busy, 1'b0);
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (req0 || req1) round(1'b0, 1'b0, w);
        end
        lock0 = 1'b0; lock1 = 1'b0;

        // Reset during ACC of a write to 0x30
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h30; wdata0 = 8'hA7;
        @(posedge clk); @(negedge clk);
        chk("racc_gnt0", gnt0, 1'b1);
        chk("racc_wr_en", mem_wr_en, 1'b1);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("racc_mem30", mem[8'h30], 8'hA7);
        chk("racc_done", {done0, done1}, 2'b00);
        chk("racc_gnt", {gnt0, gnt1}, 2'b00);
        chk("racc_busy_we", {busy, mem_wr_en}, 2'b00);
        chk("racc_addr", mem_addr, 8'h00);
        chk("racc_wdata", mem_wr_data, 8'h00);
        chk("racc_rdata", rdata, 8'h00);
        chk("racc_owner", owner, 1'b1);
        req0 = 1'b0; reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("racc_after_done", {done0, done1}, 2'b00);
        chk("racc_after_gnt", {gnt0, gnt1, busy}, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
